// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: write-pointer sync, read pointers, empty flag and a registered valid/ready output stage.
// Optional read-level tracking is built only when FIFO_RD_LEVEL_EN is defined.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    input  logic                  dready,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  ralmost_empty
);

    logic [ADDR_WIDTH:0] rq1_wptr_r;
    logic [ADDR_WIDTH:0] rq2_wptr_r;
    logic [ADDR_WIDTH:0] rbin_r;
    logic                rinc_s;
    logic [ADDR_WIDTH:0] rbin_next_s;
    logic [ADDR_WIDTH:0] rgray_next_s;

    assign raddr = rbin_r[ADDR_WIDTH-1:0];

    // Fetch decision and next read pointer in binary and Gray form
    always_comb begin
        rinc_s       = 1'b0;
        rbin_next_s  = rbin_r;
        rgray_next_s = '0;
        if (!rempty && (!dvalid || dready)) begin
            rinc_s = 1'b1;
        end else begin
            rinc_s = 1'b0;
        end
        rbin_next_s  = rbin_r + {{ADDR_WIDTH{1'b0}}, rinc_s};
        rgray_next_s = (rbin_next_s >> 1) ^ rbin_next_s;
    end

    // Two-flop synchronizer for the Gray write pointer
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rq1_wptr_r <= '0;
            rq2_wptr_r <= '0;
        end else begin
            rq1_wptr_r <= wptr;
            rq2_wptr_r <= rq1_wptr_r;
        end
    end

    // Read pointers and the empty flag; rempty compares against the lagging synced pointer, so it is pessimistic
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_r <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin_r <= rbin_next_s;
            rptr   <= rgray_next_s;
            rempty <= (rgray_next_s == rq2_wptr_r);
        end
    end

    // Output stage: a fetch refills dout (even while popping), otherwise a pop just drops dvalid
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else if (rinc_s) begin
            dout   <= rdata;
            dvalid <= 1'b1;
        end else if (dvalid && dready) begin
            dvalid <= 1'b0;
        end else begin
            dvalid <= dvalid;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [ADDR_WIDTH:0] THRESH_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [ADDR_WIDTH:0] level_next_s;

    // Words still in memory after this edge's fetch; the word held in dout is excluded
    always_comb begin
        level_next_s = '0;
        level_next_s = gray2bin(rq2_wptr_r) - rbin_next_s;
    end

    // Registered level and almost-empty flag
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rlevel        <= level_next_s;
            ralmost_empty <= (level_next_s <= THRESH_C);
        end
    end
`else
    assign rlevel        = '0;
    assign ralmost_empty = 1'b1;
`endif

endmodule
